load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Parametrised, multi-cycle load data path that supersedes the combinational byte/half extractor. Accepts a load request (address plus type) over valid/ready, issues one or two aligned reads to the data memory port, merges bytes across a word boundary when needed, and returns a sign- or zero-extended result over valid/ready. Sits between the LSU request decode and the data memory/bus adapter.

Parameters:
DATA_W, 32, memory word and result width in bits; 32 or 64 only. BYTES = DATA_W/8, OFS_W = log2(BYTES).
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  load request valid
req_ready  out  1  unit can accept a request
req_addr  in  ADDR_W  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword only when DATA_W=64)
req_unsigned  in  1  1=zero-extend, 0=sign-extend
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  aligned read address; low OFS_W bits always 0
mem_rvalid  in  1  read data valid, one pulse per accepted request
mem_rdata  in  DATA_W  read data, little-endian
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  DATA_W  extended result
rsp_fault  out  1  misaligned-access fault (feature only)

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. Exactly one memory request outstanding.
- Reset: state IDLE; req_ready=1; mem_req_valid=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_fault=0. Reset asserted mid-operation abandons the load immediately; the memory side shares rst_n, so no stale mem_rvalid follows.
- req_ready=1 only in IDLE. On req handshake: latch addr, size, unsigned; N = 1<<size (size=3 with DATA_W=32 is treated as size=2); ofs = addr[OFS_W-1:0]; split = (ofs+N > BYTES). Go to REQ0.
- REQ0: mem_req_valid=1, mem_addr = addr with low OFS_W bits cleared. On mem_req_ready go to WAIT0.
- WAIT0: on mem_rvalid capture word0; go to REQ1 if split, else RESP.
- REQ1: mem_addr = aligned addr + BYTES, modulo 2^ADDR_W (wraps to 0). On mem_req_ready go to WAIT1.
- WAIT1: on mem_rvalid capture word1; go to RESP.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- Merge: take {word1, word0}, shift right by ofs*8, keep the low N bytes, then extend to DATA_W. Sign bit is bit 8N-1. word1 = 0 when not split.
- RESP: rsp_valid=1. rsp_data and rsp_fault are registered and stable until rsp_ready. Handshake returns to IDLE. A new request is accepted no earlier than the following cycle.
- Latency with zero-wait memory (mem_req_ready=1, mem_rvalid the cycle after the request handshake): accept at T, mem request at T+1, data at T+2, rsp_valid at T+3. A split load adds 2 cycles.
- Backpressure on mem_req_ready, mem_rvalid and rsp_ready may last arbitrarily long. Outputs hold during any stall.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: a request with addr not a multiple of N (natural alignment; MIPS AdEL semantics) issues no memory request. The unit goes IDLE->RESP on the next edge with rsp_fault=1 and rsp_data=0. REQ1/WAIT1 are unreachable.
- Undefined: rsp_fault is tied 0 and misaligned loads are split as above.

Test Plan:
Memory setup: DATA_W=32; mem[0x100]=0xDDCCBBAA, mem[0x104]=0x44332211.
1. Byte load at addr 0x103: signed -> rsp_data=0xFFFFFFDD; unsigned -> 0x000000DD. Exactly one mem request, to 0x100. rsp_valid at T+3.
2. Half load at addr 0x102: signed -> 0xFFFFDDCC; unsigned -> 0x0000DDCC.
3. Word load at addr 0x102 -> requests to 0x100 then 0x104, rsp_data=0x2211DDCC, rsp_valid at T+5. With MISALIGN_TRAP_EN: rsp_fault=1, rsp_data=0, zero mem requests, rsp_valid at T+1.
4. Signed half load at addr 0x103 (split) -> 0x000011DD. Word load at addr 0xFFFFFFFE -> second mem_addr=0x00000000.
5. Stalls: mem_req_ready low 3 cycles, mem_rvalid delayed 4 cycles, rsp_ready low 5 cycles -> mem_addr, rsp_data and rsp_valid held stable, req_ready=0 throughout, correct result on release.
6. rst_n asserted in WAIT1 -> all outputs return to reset values asynchronously. After release, a word load at 0x100 returns 0xDDCCBBAA.

Source files
------------

// File: rtl/load_align_unit.sv
// Multi-cycle load aligner: one or two aligned memory reads, byte merge, sign/zero extension.
// Optional MISALIGN_TRAP_EN: naturally misaligned loads fault without touching memory.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              split_q, split_d;
  logic [DATA_W-1:0] word0_q, word0_d;

  logic [1:0]        size_s;
  logic [4:0]        nbytes_s;
  logic [OFS_W-1:0]  ofs_s;
  logic              split_s;
  logic              trap_s;
  logic [ADDR_W-1:0] aligned_s;

  // Shift the two-word window down to the addressed byte, keep N bytes, extend.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [2*DATA_W-1:0] pair,
    input logic [OFS_W-1:0]    ofs,
    input logic [1:0]          sz,
    input logic                uns
  );
    logic [DATA_W-1:0] low;
    logic [DATA_W-1:0] mask;
    logic              sign;
    low = DATA_W'(pair >> {ofs, 3'b000});
    case (sz)
      2'd0: begin mask = DATA_W'(8'hFF);         sign = low[7];        end
      2'd1: begin mask = DATA_W'(16'hFFFF);      sign = low[15];       end
      2'd2: begin mask = DATA_W'(32'hFFFF_FFFF); sign = low[31];       end
      default: begin mask = '1;                  sign = low[DATA_W-1]; end
    endcase
    sign = sign & ~uns;
    return (low & mask) | (~mask & {DATA_W{sign}});
  endfunction

  // Request decode: a dword on a 32-bit datapath degrades to a word load.
  always_comb begin
    size_s = req_size;
    if ((DATA_W == 32) && (req_size == 2'd3)) begin
      size_s = 2'd2;
    end else begin
      size_s = req_size;
    end
    nbytes_s  = 5'd1 << size_s;
    ofs_s     = req_addr[OFS_W-1:0];
    split_s   = (5'(ofs_s) + nbytes_s) > 5'(BYTES);
    aligned_s = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_s = (5'(ofs_s) & (nbytes_s - 5'd1)) != 5'd0;
`else
  assign trap_s = 1'b0;
`endif

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_fault_d     = rsp_fault_q;
    ofs_d           = ofs_q;
    size_d          = size_q;
    uns_d           = uns_q;
    split_d         = split_q;
    word0_d         = word0_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          ofs_d       = ofs_s;
          size_d      = size_s;
          uns_d       = req_unsigned;
          split_d     = split_s;
          req_ready_d = 1'b0;
          if (trap_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d         = REQ0;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = aligned_s;
            rsp_fault_d     = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ0, REQ1: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = (state_q == REQ0) ? WAIT0 : WAIT1;
        end else begin
          state_d = state_q;
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          word0_d = mem_rdata;
          if (split_q) begin
            state_d         = REQ1;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = mem_addr_q + ADDR_W'(BYTES);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = extend_load({{DATA_W{1'b0}}, mem_rdata}, ofs_q, size_q, uns_q);
          end
        end else begin
          state_d = WAIT0;
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = extend_load({mem_rdata, word0_q}, ofs_q, size_q, uns_q);
        end else begin
          state_d = WAIT1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d         = IDLE;
        req_ready_d     = 1'b1;
        mem_req_valid_d = 1'b0;
        rsp_valid_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_fault_q     <= 1'b0;
      ofs_q           <= '0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      split_q         <= 1'b0;
      word0_q         <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_fault_q     <= rsp_fault_d;
      ofs_q           <= ofs_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      split_q         <= split_d;
      word0_q         <= word0_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_fault     = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (DATA_W=32) with a small memory responder.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;
  int stall_until = 0;
  int rdelay = 0;
  int cd = 0;
  int req_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] req_last = 32'h0;
  logic [31:0] req_prev = 32'h0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDDCC_BBAA;
      32'h0000_0104: return 32'h4433_2211;
      32'hFFFF_FFFC: return 32'h8765_4321;
      32'h0000_0000: return 32'h0FED_CBA9;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Memory responder: one outstanding read, rvalid rdelay cycles after the handshake.
  initial begin
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(pend_addr);
        end
      end
      mem_req_ready = (cyc >= stall_until);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        pend_addr = mem_addr;
        cd        = 1 + rdelay;
        req_prev  = req_last;
        req_last  = mem_addr;
        req_cnt++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input int rsp_stall, output logic [31:0] data, output logic fault,
                         output int lat, output int unstable);
    logic [31:0] prev_ma;
    logic        prev_mv;
    unstable = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = uns; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    prev_ma = mem_addr;
    prev_mv = 1'b0;
    while (!rsp_valid && lat < 60) begin
      if (req_ready) unstable++;
      if (prev_mv && mem_req_valid && (mem_addr != prev_ma)) unstable++;
      prev_mv = mem_req_valid;
      prev_ma = mem_addr;
      @(negedge clk);
      lat++;
    end
    data  = rsp_data;
    fault = rsp_fault;
    repeat (rsp_stall) begin
      @(negedge clk);
      if (!rsp_valid || (rsp_data != data) || (rsp_fault != fault) || req_ready) unstable++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid || !req_ready) unstable++;
  endtask

  task automatic load_and_check(input string tag, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input int rsp_stall, input logic [31:0] exp_data,
                                input logic exp_fault, input int exp_lat, input int exp_cnt);
    logic [31:0] d;
    logic        f;
    int          lat;
    int          unst;
    int          base;
    base = req_cnt;
    do_load(a, sz, uns, rsp_stall, d, f, lat, unst);
    check_eq({tag, "_data"}, d, exp_data);
    check_eq({tag, "_fault"}, 32'(f), 32'(exp_fault));
    check_eq({tag, "_nreq"}, 32'(req_cnt - base), 32'(exp_cnt));
    check_eq({tag, "_stable"}, 32'(unst), 32'd0);
    if (exp_lat > 0) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_rsp_fault", 32'(rsp_fault), 32'd0);

    load_and_check("b103s", 32'h103, 2'd0, 1'b0, 0, 32'hFFFF_FFDD, 1'b0, 3, 1);
    check_eq("b103s_addr", req_last, 32'h100);
    load_and_check("b103u", 32'h103, 2'd0, 1'b1, 0, 32'h0000_00DD, 1'b0, 3, 1);
    load_and_check("b100s", 32'h100, 2'd0, 1'b0, 0, 32'hFFFF_FFAA, 1'b0, 3, 1);
    load_and_check("h102s", 32'h102, 2'd1, 1'b0, 0, 32'hFFFF_DDCC, 1'b0, 3, 1);
    load_and_check("h102u", 32'h102, 2'd1, 1'b1, 0, 32'h0000_DDCC, 1'b0, 3, 1);
    load_and_check("h106u", 32'h106, 2'd1, 1'b1, 0, 32'h0000_4433, 1'b0, 3, 1);
    load_and_check("d100", 32'h100, 2'd3, 1'b0, 0, 32'hDDCC_BBAA, 1'b0, 3, 1);
`ifdef MISALIGN_TRAP_EN
    load_and_check("w102", 32'h102, 2'd2, 1'b0, 0, 32'h0, 1'b1, 1, 0);
    load_and_check("h103s", 32'h103, 2'd1, 1'b0, 0, 32'h0, 1'b1, 1, 0);
    load_and_check("wwrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 0, 32'h0, 1'b1, 1, 0);
`else
    load_and_check("w102", 32'h102, 2'd2, 1'b0, 0, 32'h2211_DDCC, 1'b0, 5, 2);
    check_eq("w102_addr0", req_prev, 32'h100);
    check_eq("w102_addr1", req_last, 32'h104);
    load_and_check("h103s", 32'h103, 2'd1, 1'b0, 0, 32'h0000_11DD, 1'b0, 5, 2);
    load_and_check("wwrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 0, 32'hCBA9_8765, 1'b0, 5, 2);
    check_eq("wwrap_addr0", req_prev, 32'hFFFF_FFFC);
    check_eq("wwrap_addr1", req_last, 32'h0);
`endif

    // Stalls on every handshake; the task verifies outputs hold meanwhile.
    stall_until = cyc + 5;
    rdelay = 4;
    load_and_check("stall", 32'h100, 2'd2, 1'b0, 5, 32'hDDCC_BBAA, 1'b0, -1, 1);
    check_eq("stall_addr", req_last, 32'h100);
    stall_until = 0;
    rdelay = 20;

    // Reset while the second read is outstanding.
    base = req_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h102; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while ((req_cnt - base) < 2 && !rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifndef MISALIGN_TRAP_EN
    check_eq("mid_nreq", 32'(req_cnt - base), 32'd2);
`endif
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_req_ready", 32'(req_ready), 32'd1);
    check_eq("mid_mem_valid", 32'(mem_req_valid), 32'd0);
    check_eq("mid_mem_addr", mem_addr, 32'h0);
    check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rsp_data", rsp_data, 32'h0);
    check_eq("mid_rsp_fault", 32'(rsp_fault), 32'd0);
    rdelay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
    load_and_check("post_w100", 32'h100, 2'd2, 1'b0, 0, 32'hDDCC_BBAA, 1'b0, 3, 1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
